routing_odd_even_adaptive: RTL



---
 rtl/routing_odd_even_adaptive.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/routing_odd_even_adaptive.sv
// Registered odd-even adaptive route calculator, one request channel per router input port.
// Optional build macro ROUTE_REROUTE_EN: reroute a held adaptive route whose chosen output stays starved.
module routing_odd_even_adaptive #(
  parameter int X_LOC       = 0,
  parameter int Y_LOC       = 0,
  parameter int X_NODES     = 4,
  parameter int Y_NODES     = 4,
  parameter int N           = 5,
  parameter int CW          = 3,
  parameter int STALL_LIMIT = 4,
  localparam int XW = (X_NODES > 1) ? $clog2(X_NODES) : 1,
  localparam int YW = (Y_NODES > 1) ? $clog2(Y_NODES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           i_req_valid,
  output logic [N-1:0]           o_req_ready,
  input  logic [N-1:0][XW-1:0]   i_x_source,
  input  logic [N-1:0][XW-1:0]   i_x_dest,
  input  logic [N-1:0][YW-1:0]   i_y_dest,
  input  logic [4:0][CW-1:0]     i_credit,
  output logic [N-1:0]           o_route_valid,
  output logic [N-1:0][4:0]      o_route_dir,
  output logic [N-1:0]           o_route_adaptive,
  output logic [N-1:0]           o_route_err,
  input  logic [N-1:0]           i_route_ack
);

  localparam logic [XW-1:0] XL   = XW'(X_LOC);
  localparam logic [YW-1:0] YL   = YW'(Y_LOC);
  localparam logic [XW:0]   XLIM = (XW+1)'(X_NODES);
  localparam logic [YW:0]   YLIM = (YW+1)'(Y_NODES);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  function automatic logic [CW-1:0] credit_of(input logic [4:0] oh, input logic [4:0][CW-1:0] cr);
    logic [CW-1:0] r;
    r = '0;
    for (int d = 0; d < 5; d++)
      if (oh[d]) r = cr[d];
    return r;
  endfunction

  for (genvar c = 0; c < N; c++) begin : g_ch
    logic [XW-1:0] sx, dxv;
    logic [YW-1:0] dyv;
    logic [4:0]    cand, ns, lo, hi, pick;
    logic [CW-1:0] clo, chi;
    logic          two, tie, err_c, accept;
    state_t        state;
    logic          rr, valid_q, adap_q, err_q;
    logic [4:0]    dir_q;
`ifdef ROUTE_REROUTE_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [4:0]    alt_q;
    logic [SW-1:0] cnt_q;
`endif

    assign sx  = i_x_source[c];
    assign dxv = i_x_dest[c];
    assign dyv = i_y_dest[c];

    // Odd-even turn model: east-to-north/south turns are forbidden in even columns, north/south-to-west in odd ones.
    always_comb begin
      cand  = '0;
      err_c = 1'b0;
      ns    = (dyv > YL) ? 5'b00010 : 5'b01000;
      if (({1'b0, dxv} >= XLIM) || ({1'b0, dyv} >= YLIM)) begin
        err_c = 1'b1;
      end else if (dxv == XL) begin
        cand = (dyv == YL) ? 5'b00001 : ns;
      end else if (dxv > XL) begin
        if (dyv == YL) begin
          cand = 5'b00100;
        end else begin
          if (XL[0] || (sx == XL))
            cand |= ns;
          if (dxv[0] || (({1'b0, dxv} - {1'b0, XL}) >= (XW+1)'(2)))
            cand |= 5'b00100;
        end
      end else begin
        cand = 5'b10000;
        if ((dyv != YL) && !XL[0])
          cand |= ns;
      end
    end

    always_comb begin
      lo   = cand & (~cand + 5'd1);
      hi   = cand & ~lo;
      two  = |hi;
      clo  = credit_of(lo, i_credit);
      chi  = credit_of(hi, i_credit);
      tie  = 1'b0;
      pick = cand;
      if (err_c) begin
        pick = 5'b00001;
      end else if (two) begin
        if (clo > chi)
          pick = lo;
        else if (chi > clo)
          pick = hi;
        else begin
          tie  = 1'b1;
          pick = rr ? hi : lo;
        end
      end
    end

    assign o_req_ready[c] = (state == IDLE) | i_route_ack[c];
    assign accept         = i_req_valid[c] & o_req_ready[c];

    // An ack with a new request reloads HOLD directly, so a channel can route every cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= IDLE;
        valid_q <= 1'b0;
        dir_q   <= '0;
        adap_q  <= 1'b0;
        err_q   <= 1'b0;
        rr      <= 1'b0;
`ifdef ROUTE_REROUTE_EN
        alt_q   <= '0;
        cnt_q   <= '0;
`endif
      end else if (accept) begin
        state   <= HOLD;
        valid_q <= 1'b1;
        dir_q   <= pick;
        adap_q  <= two;
        err_q   <= err_c;
        if (tie)
          rr <= ~rr;
`ifdef ROUTE_REROUTE_EN
        alt_q   <= cand & ~pick;
        cnt_q   <= '0;
`endif
      end else if ((state == HOLD) && i_route_ack[c]) begin
        state   <= IDLE;
        valid_q <= 1'b0;
`ifdef ROUTE_REROUTE_EN
        cnt_q   <= '0;
`endif
      end
`ifdef ROUTE_REROUTE_EN
      else if ((state == HOLD) && adap_q && (credit_of(dir_q, i_credit) == '0)) begin
        if ((cnt_q >= SW'(STALL_LIMIT - 1)) && (credit_of(alt_q, i_credit) != '0)) begin
          dir_q <= alt_q;
          alt_q <= dir_q;
          cnt_q <= '0;
        end else if (cnt_q < SW'(STALL_LIMIT)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
`endif
    end

    assign o_route_valid[c]    = valid_q;
    assign o_route_dir[c]      = dir_q;
    assign o_route_adaptive[c] = adap_q;
    assign o_route_err[c]      = err_q;
  end

endmodule
